// File: rtl/vga_pic_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pic_gen
// Description : Zero-latency RGB565 pattern source (colour bars, bouncing box,
//               scrolling checkerboard) with per-frame animation state.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pic_gen #(
    parameter int          H_VALID    = 640,
    parameter int          V_VALID    = 480,
    parameter int          BOX_SIZE   = 64,
    parameter int          STEP       = 2,
    parameter logic [15:0] BOX_COLOUR = 16'hF800,
    parameter logic [15:0] BG_COLOUR  = 16'h001F
) (
    input  logic        Clk_int,
    input  logic        Sys_Rst_n,
    input  logic        V_sys,
    input  logic        mode_key,
    input  logic [9:0]  jpg_x,
    input  logic [9:0]  jpg_y,
    output logic [15:0] jpg_colour,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        BARS  = 2'd0,
        BOX   = 2'd1,
        CHECK = 2'd2
    } mode_t;

    localparam logic [10:0] X_MAX   = 11'(H_VALID - BOX_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_VALID - BOX_SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] SIZE_W  = 11'(BOX_SIZE);

    logic        v_sys_d;
    mode_t       mode, mode_nxt;
    mode_t       mode_req, mode_req_nxt;
    logic [9:0]  box_x, box_y;
    logic        dir_x, dir_y;          // 1 = moving towards larger coordinates
    logic [9:0]  ofs;

    // Frame tick: registered rising edge of the controller's vsync
    always_ff @(posedge Clk_int) begin
        if (!Sys_Rst_n) begin
            v_sys_d    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            v_sys_d    <= V_sys;
            frame_tick <= V_sys & ~v_sys_d;
        end
    end

    always_ff @(posedge Clk_int) begin
        if (!Sys_Rst_n) begin
            mode     <= BARS;
            mode_req <= BARS;
        end else begin
            mode     <= mode_nxt;
            mode_req <= mode_req_nxt;
        end
    end

    // The displayed mode only follows the request on a frame boundary
    always_comb begin
        mode_nxt     = mode;
        mode_req_nxt = mode_req;
        if (frame_tick) begin
            mode_nxt = mode_req;
        end
        if (mode_key) begin
            case (mode_req)
                BARS:    mode_req_nxt = BOX;
                BOX:     mode_req_nxt = CHECK;
                default: mode_req_nxt = BARS;
            endcase
        end
    end

    always_ff @(posedge Clk_int) begin
        if (!Sys_Rst_n) begin
            box_x <= 10'd0;
            box_y <= 10'd0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (frame_tick && mode == BOX) begin
            if (dir_x) begin
                if ({1'b0, box_x} + STEP_W >= X_MAX) begin
                    box_x <= X_MAX[9:0];
                    dir_x <= 1'b0;
                end else begin
                    box_x <= box_x + STEP_W[9:0];
                end
            end else if ({1'b0, box_x} <= STEP_W) begin
                box_x <= 10'd0;
                dir_x <= 1'b1;
            end else begin
                box_x <= box_x - STEP_W[9:0];
            end

            if (dir_y) begin
                if ({1'b0, box_y} + STEP_W >= Y_MAX) begin
                    box_y <= Y_MAX[9:0];
                    dir_y <= 1'b0;
                end else begin
                    box_y <= box_y + STEP_W[9:0];
                end
            end else if ({1'b0, box_y} <= STEP_W) begin
                box_y <= 10'd0;
                dir_y <= 1'b1;
            end else begin
                box_y <= box_y - STEP_W[9:0];
            end
        end
    end

    always_ff @(posedge Clk_int) begin
        if (!Sys_Rst_n) begin
            ofs <= 10'd0;
        end else if (frame_tick && mode == CHECK) begin
            ofs <= ofs + 10'd1;
        end
    end

    logic [2:0]  band;
    logic [9:0]  chk_sum;
    logic        in_box;
    logic        unused_sum_bits;

    always_comb begin
        band = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (jpg_x >= 10'(i * 80)) begin
                band = 3'(i);
            end
        end
    end

    assign chk_sum = jpg_x + ofs;
    assign unused_sum_bits = ^{chk_sum[9:6], chk_sum[4:0]};

    assign in_box = (jpg_x >= box_x) && ({1'b0, jpg_x} < {1'b0, box_x} + SIZE_W) &&
                    (jpg_y >= box_y) && ({1'b0, jpg_y} < {1'b0, box_y} + SIZE_W);

    always_comb begin
        jpg_colour = 16'h0000;
        if (jpg_x < 10'(H_VALID) && jpg_y < 10'(V_VALID)) begin
            case (mode)
                BARS: begin
                    case (band)
                        3'd0:    jpg_colour = 16'hFFFF;
                        3'd1:    jpg_colour = 16'hFFE0;
                        3'd2:    jpg_colour = 16'h07FF;
                        3'd3:    jpg_colour = 16'h07E0;
                        3'd4:    jpg_colour = 16'hF81F;
                        3'd5:    jpg_colour = 16'hF800;
                        3'd6:    jpg_colour = 16'h001F;
                        default: jpg_colour = 16'h0000;
                    endcase
                end
                BOX:     jpg_colour = in_box ? BOX_COLOUR : BG_COLOUR;
                CHECK:   jpg_colour = (chk_sum[5] ^ jpg_y[5]) ? 16'hFFFF : 16'h0000;
                default: jpg_colour = 16'h0000;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pic_gen
// Description : Directed + randomized bench for vga_pic_gen against a
//               frame-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pic_gen;

    logic        Clk_int   = 1'b0;
    logic        Sys_Rst_n = 1'b0;
    logic        V_sys     = 1'b0;
    logic        mode_key  = 1'b0;
    logic [9:0]  jpg_x     = '0;
    logic [9:0]  jpg_y     = '0;
    logic [15:0] jpg_colour;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    vga_pic_gen dut (
        .Clk_int    (Clk_int),
        .Sys_Rst_n  (Sys_Rst_n),
        .V_sys      (V_sys),
        .mode_key   (mode_key),
        .jpg_x      (jpg_x),
        .jpg_y      (jpg_y),
        .jpg_colour (jpg_colour),
        .frame_tick (frame_tick)
    );

    always #50 Clk_int = ~Clk_int;

    // Behavioural model: modes 0=bars 1=box 2=check, signed directions
    int m_vd, m_tick, m_mode, m_req, m_bx, m_by, m_dx, m_dy, m_ofs;
    int bar_col [8] = '{32'hFFFF, 32'hFFE0, 32'h07FF, 32'h07E0,
                        32'hF81F, 32'hF800, 32'h001F, 32'h0000};

    function automatic int ref_colour(int x, int y);
        if (x >= 640 || y >= 480) return 0;
        if (m_mode == 0) return bar_col[x / 80];
        if (m_mode == 1)
            return (x >= m_bx && x < m_bx + 64 && y >= m_by && y < m_by + 64) ? 32'hF800 : 32'h001F;
        return ((((x + m_ofs) % 1024) / 32) % 2 != (y / 32) % 2) ? 32'hFFFF : 32'h0000;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic v, input logic k);
        int nx, ny;
        Sys_Rst_n = rn;
        V_sys     = v;
        mode_key  = k;
        @(posedge Clk_int);
        if (!rn) begin
            m_vd = 0; m_tick = 0; m_mode = 0; m_req = 0;
            m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_ofs = 0;
        end else begin
            if (m_tick != 0) begin
                if (m_mode == 1) begin
                    nx = m_bx + 2 * m_dx;
                    ny = m_by + 2 * m_dy;
                    if (m_dx > 0 && nx >= 576) begin nx = 576; m_dx = -1; end
                    else if (m_dx < 0 && nx <= 0) begin nx = 0; m_dx = 1; end
                    if (m_dy > 0 && ny >= 416) begin ny = 416; m_dy = -1; end
                    else if (m_dy < 0 && ny <= 0) begin ny = 0; m_dy = 1; end
                    m_bx = nx;
                    m_by = ny;
                end
                if (m_mode == 2) m_ofs = (m_ofs + 1) % 1024;
                m_mode = m_req;
            end
            if (k) m_req = (m_req + 1) % 3;
            m_tick = (v && m_vd == 0) ? 1 : 0;
            m_vd   = v ? 1 : 0;
        end
        #1;
        mode_key = 1'b0;
        chk("frame_tick", int'(frame_tick), m_tick);
    endtask

    task automatic frame();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic pix(input int x, input int y);
        jpg_x = 10'(x);
        jpg_y = 10'(y);
        #1;
        chk($sformatf("pix(%0d,%0d)", x, y), int'(jpg_colour), ref_colour(x, y));
    endtask

    task automatic pixk(input int x, input int y, input int k);
        jpg_x = 10'(x);
        jpg_y = 10'(y);
        #1;
        chk($sformatf("pixk(%0d,%0d)", x, y), int'(jpg_colour), k);
    endtask

    task automatic rpix(input int n);
        for (int i = 0; i < n; i++) pix($urandom_range(0, 719), $urandom_range(0, 539));
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_mode"},  int'(dut.mode),  m_mode);
        chk({tag, "_box_x"}, int'(dut.box_x), m_bx);
        chk({tag, "_box_y"}, int'(dut.box_y), m_by);
        chk({tag, "_ofs"},   int'(dut.ofs),   m_ofs);
    endtask

    initial begin
        int box_ticks;

        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk_state("reset");
        chk("reset_mode_k", int'(dut.mode), 0);

        step(1'b1, 1'b0, 1'b0);
        pixk(0, 0, 16'hFFFF);
        pixk(80, 5, 16'hFFE0);
        pixk(639, 0, 16'h0000);
        pixk(700, 0, 16'h0000);
        pixk(0, 480, 16'h0000);
        rpix(12);

        // One key mid-frame: bars stay until the next tick
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("bars_hold", int'(dut.mode), 0);
        rpix(6);
        frame();
        chk_state("box_enter");
        pixk(10, 10, 16'hF800);
        pixk(64, 10, 16'h001F);
        frame();
        box_ticks = 1;
        pixk(1, 1, 16'h001F);
        pixk(2, 2, 16'hF800);
        chk_state("box_first");

        while (box_ticks < 208) begin frame(); box_ticks++; end
        chk("box_y_208", int'(dut.box_y), 416);
        chk_state("tick208");
        frame(); box_ticks++;
        chk("box_y_209", int'(dut.box_y), 414);
        while (box_ticks < 288) begin frame(); box_ticks++; end
        chk("box_x_288", int'(dut.box_x), 576);
        pixk(639, m_by, 16'hF800);
        pixk(639, m_by + 63, 16'hF800);
        pix(639, m_by + 64);
        frame(); box_ticks++;
        chk("box_x_289", int'(dut.box_x), 574);
        pixk(639, m_by, 16'h001F);
        pixk(637, m_by, 16'hF800);
        chk_state("tick289");
        rpix(16);

        // Checkerboard
        step(1'b1, 1'b0, 1'b1);
        frame();
        chk("check_mode", int'(dut.mode), 2);
        pixk(0, 0, 16'h0000);
        pixk(32, 0, 16'hFFFF);
        pixk(32, 32, 16'h0000);
        frame();
        pixk(31, 0, 16'hFFFF);
        rpix(10);
        for (int i = 0; i < 1023; i++) frame();
        chk("ofs_wrap", int'(dut.ofs), 0);
        chk_state("check_wrap");
        rpix(10);

        // Key in the same cycle as frame_tick
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("tick_key_hold", int'(dut.mode), 2);
        frame();
        chk("tick_key_apply", int'(dut.mode), 0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        frame();
        chk("double_key", int'(dut.mode), 2);
        chk_state("double_key");

        // Reset during box mode at (100,100)
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        frame();
        for (int i = 0; i < 50; i++) frame();
        chk("pre_rst_x", int'(dut.box_x), 100);
        chk("pre_rst_y", int'(dut.box_y), 100);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_mode", int'(dut.mode), 0);
        chk("rst_box_x", int'(dut.box_x), 0);
        chk("rst_box_y", int'(dut.box_y), 0);
        chk("rst_tick", int'(frame_tick), 0);
        pixk(0, 0, 16'hFFFF);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_state("post_rst");
        rpix(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
